// File: rtl/tx_rx_pkg.sv
// Shared definitions for the tx line driver and the rx receiver.
//
// Contents:
//   rx_state_t     receiver FSM state encoding (ARM, IDLE, DATA, STOP)
//   DATA_W_DEF     default number of data bits per frame
//   IDLE_LEVEL     line level between frames
//   START_LEVEL    line level of the start bit
//   STOP_LEVEL_DEF default line level of the stop bit
//   cnt_width()    width of a down-counter that must hold n-1
package tx_rx_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } rx_state_t;

  localparam int   DATA_W_DEF     = 16;
  localparam logic IDLE_LEVEL     = 1'b1;
  localparam logic START_LEVEL    = 1'b0;
  localparam logic STOP_LEVEL_DEF = 1'b0;

  // A one-bit frame still needs a one-bit counter, so never return 0.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx.sv
// Serial frame receiver, one line bit per clock, no oversampling.
//
// Frame on linha: start bit (0), DATA_W data bits MSB first, stop bit at
// STOP_LEVEL, then at least one idle cycle at 1. A good frame is placed in
// a one-entry output buffer offered with a valid/ack handshake.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   linha      in   serial line, idles at 1
//   ack        in   consumer takes palavra this cycle when valid=1
//   palavra    out  DATA_W  received word, MSB = first data bit
//   valid      out  palavra holds an unconsumed word
//   busy       out  a frame is in progress (DATA or STOP)
//   frame_err  out  one-cycle pulse: stop bit was not STOP_LEVEL
//   overrun    out  one-cycle pulse: good word dropped, buffer still full
module rx
  import tx_rx_pkg::*;
#(
  parameter int   DATA_W     = DATA_W_DEF,
  parameter logic STOP_LEVEL = STOP_LEVEL_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              linha,
  input  logic              ack,
  output logic [DATA_W-1:0] palavra,
  output logic              valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = cnt_width(DATA_W);

  rx_state_t          state;
  rx_state_t          state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shreg;

  logic               load_cnt;
  logic               shift_en;
  logic               stop_ok;
  logic               stop_bad;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ARM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    load_cnt  = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      // ARM refuses to look for a start bit until the line has been seen
      // idle, so a line held low through reset is never taken as a start.
      ARM: begin
        if (linha == IDLE_LEVEL) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (linha == START_LEVEL) begin
          state_nxt = DATA;
          load_cnt  = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (cnt == '0) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        state_nxt = ARM;
        if (linha == STOP_LEVEL) begin
          stop_ok = 1'b1;
        end else begin
          stop_bad = 1'b1;
        end
      end
      default: begin
        state_nxt = ARM;
      end
    endcase
  end

  // Deserializer: bit counter and shift register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      shreg <= '0;
    end else begin
      if (load_cnt) begin
        cnt <= CNT_W'(DATA_W - 1);
      end else if (shift_en && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (shift_en) begin
        shreg <= {shreg[DATA_W-2:0], linha};
      end
    end
  end

  // busy is taken from the next-state value so it is a plain flop output,
  // matching the registered state without any path from linha to the pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_nxt == DATA) || (state_nxt == STOP);
    end
  end

  // Output buffer and error pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      palavra   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (stop_ok) begin
        // A same-cycle ack frees the slot, so the new word can replace
        // the one being consumed without a bubble.
        if (!valid || ack) begin
          palavra <= shreg;
          valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx.sv
module tb_rx;

  localparam int W = 16;

  logic          clock;
  logic          reset;
  logic          linha;
  logic          ack;
  logic [W-1:0]  palavra;
  logic          valid;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  int errors;
  int checks;

  rx #(.DATA_W(W), .STOP_LEVEL(1'b0)) dut (
    .clock     (clock),
    .reset     (reset),
    .linha     (linha),
    .ack       (ack),
    .palavra   (palavra),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic tick(input logic l, input logic a);
    linha = l;
    ack   = a;
    @(posedge clock);
    #1;
  endtask

  // Drive one full frame. ack is held low except during the stop cycle.
  // Returns busy cycles seen and whether any error pulse appeared mid-frame.
  task automatic send_frame(input logic [W-1:0] word, input logic stopb,
                            input logic ack_stop, output int busy_cnt,
                            output int pulses);
    busy_cnt = 0;
    pulses   = 0;
    tick(1'b0, 1'b0);
    busy_cnt += int'(busy);
    pulses   += int'(frame_err | overrun);
    for (int i = W - 1; i >= 0; i--) begin
      tick(word[i], 1'b0);
      busy_cnt += int'(busy);
      pulses   += int'(frame_err | overrun);
    end
    tick(stopb, ack_stop);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         stopb;
    logic         ack_s;
    logic [W-1:0] e_pal;
    logic         e_val;
    logic         e_fe;
    logic         e_ov;
  } vec_t;

  vec_t vec [7];

  // Random-phase stimulus and reference schedule
  localparam int MAXC = 4096;
  logic         line_a [MAXC];
  logic         ack_a  [MAXC];
  logic         busy_a [MAXC];
  int           ev_a   [MAXC];   // 0 none, 1 good stop, 2 bad stop
  logic [W-1:0] evw_a  [MAXC];

  initial begin
    int bc, pc, nc;
    logic [W-1:0] mpal;
    logic mval, mfe, mov;

    errors = 0;
    checks = 0;

    vec[0] = '{16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b1, 1'b0, 1'b0};
    vec[1] = '{16'h1234, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0};
    vec[2] = '{16'hBEEF, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1};
    vec[3] = '{16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0};
    vec[4] = '{16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vec[5] = '{16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vec[6] = '{16'h00FF, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0};

    // Reset state
    reset = 1'b0;
    linha = 1'b1;
    ack   = 1'b0;
    #12;
    chk("reset_outputs", {palavra, valid, busy, frame_err, overrun}, 32'h0);
    reset = 1'b1;
    tick(1'b1, 1'b0);

    // Table-driven frames, each followed by the minimum single idle cycle
    for (int k = 0; k < 7; k++) begin
      send_frame(vec[k].data, vec[k].stopb, vec[k].ack_s, bc, pc);
      chk($sformatf("busy_cycles[%0d]", k), bc, 17);
      chk($sformatf("midframe_pulse[%0d]", k), pc, 0);
      chk($sformatf("result[%0d]", k),
          {palavra, valid, busy, frame_err, overrun},
          {vec[k].e_pal, vec[k].e_val, 1'b0, vec[k].e_fe, vec[k].e_ov});
      tick(1'b1, 1'b0);
      chk($sformatf("pulse_end[%0d]", k), {frame_err, overrun, valid},
          {2'b00, vec[k].e_val});
    end

    // ack consumes the held word
    tick(1'b1, 1'b1);
    chk("ack_consume", valid, 1'b0);
    tick(1'b1, 1'b1);
    chk("ack_idle_ignored", {valid, palavra}, {1'b0, 16'h00FF});

    // Reset released with the line stuck low: no false start
    reset = 1'b0;
    linha = 1'b0;
    #3;
    reset = 1'b1;
    bc = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      bc += int'(busy);
    end
    chk("stuck_low_busy", bc, 0);
    tick(1'b1, 1'b0);
    send_frame(16'h8000, 1'b0, 1'b0, bc, pc);
    chk("after_stuck_low", {palavra, valid, frame_err, overrun}, {16'h8000, 3'b100});
    tick(1'b1, 1'b0);

    // Reset in the middle of a frame (valid is 1 beforehand)
    tick(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick((i % 2) == 1, 1'b0);
    reset = 1'b0;
    #2;
    chk("midframe_reset", {palavra, valid, busy, frame_err, overrun}, 32'h0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    reset = 1'b1;
    tick(1'b1, 1'b0);
    send_frame(16'hAAAA, 1'b0, 1'b0, bc, pc);
    chk("after_reset_frame", {palavra, valid, frame_err, overrun, 16'(pc)},
        {16'hAAAA, 3'b100, 16'h0});
    tick(1'b1, 1'b0);

    // Randomized traffic: build line waveform and event schedule from the
    // framing rules, then track the one-entry buffer per cycle.
    for (int c = 0; c < MAXC; c++) begin
      line_a[c] = 1'b1;
      ack_a[c]  = ($urandom_range(0, 2) == 0);
      busy_a[c] = 1'b0;
      ev_a[c]   = 0;
      evw_a[c]  = '0;
    end
    nc = 2;
    for (int f = 0; f < 40; f++) begin
      logic [W-1:0] d;
      int s;
      d = W'($urandom);
      s = nc;
      line_a[s] = 1'b0;
      for (int i = 0; i < W; i++) line_a[s + 1 + i] = d[W - 1 - i];
      if ($urandom_range(0, 5) == 0) begin
        line_a[s + W + 1] = 1'b1;
        ev_a[s + W + 1]   = 2;
      end else begin
        line_a[s + W + 1] = 1'b0;
        ev_a[s + W + 1]   = 1;
      end
      evw_a[s + W + 1] = d;
      for (int c = s; c <= s + W; c++) busy_a[c] = 1'b1;
      nc = s + W + 2 + $urandom_range(1, 3);
    end
    nc += 4;

    reset = 1'b0;
    #2;
    reset = 1'b1;
    mpal = '0;
    mval = 1'b0;
    for (int c = 0; c < nc; c++) begin
      tick(line_a[c], ack_a[c]);
      mfe = 1'b0;
      mov = 1'b0;
      if (ev_a[c] == 1) begin
        if (!mval || ack_a[c]) begin
          mpal = evw_a[c];
          mval = 1'b1;
        end else begin
          mov = 1'b1;
        end
      end else begin
        if (ev_a[c] == 2) mfe = 1'b1;
        if (mval && ack_a[c]) mval = 1'b0;
      end
      chk($sformatf("random_cycle[%0d]", c),
          {palavra, valid, busy, frame_err, overrun},
          {mpal, mval, busy_a[c], mfe, mov});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx.md
Name: rx

Overview:
- Serial receiver that sits directly downstream of the `tx` line driver and consumes its `linha` output.
- Deserializes frames of one bit per clock into 16-bit words on the same clock (no oversampling, no synchronizer).
- Holds each word in a one-entry output buffer with a valid/ack handshake, and flags framing and overrun errors.

Parameters:
- DATA_W, 16, number of data bits per frame; palavra width.
- STOP_LEVEL, 1'b0, required line level during the stop-bit cycle.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- linha  input  1  serial line; idles at 1.
- ack  input  1  consumer accepts palavra this cycle when valid=1.
- palavra  output  DATA_W  received word, MSB = first data bit.
- valid  output  1  palavra holds an unconsumed word.
- busy  output  1  a frame is in progress.
- frame_err  output  1  one-cycle pulse: stop bit not equal to STOP_LEVEL.
- overrun  output  1  one-cycle pulse: new word arrived while buffer full and not acked.

Behaviour:
- Frame, one bit per clock:
  - start bit 0 (1 cycle),
  - DATA_W data bits, MSB first,
  - stop bit at STOP_LEVEL (1 cycle),
  - then at least 1 idle cycle at 1 before the next start.
- Reset (reset=0, asynchronous):
  - state=ARM;
  - palavra=0, valid=0, busy=0, frame_err=0, overrun=0;
  - shift register and counter cleared.
- States:
  - ARM: wait for linha=1, then go to IDLE. Prevents a stuck-low line, or a line already low at reset release, from being taken as a start bit.
  - IDLE: if linha=0 this cycle (start bit sampled), go to DATA and load cnt=DATA_W-1; otherwise stay.
  - DATA: shreg <= {shreg[DATA_W-2:0], linha}. If cnt==0 go to STOP, else cnt <= cnt-1. Lasts exactly DATA_W cycles.
  - STOP: sample linha.
    - If linha==STOP_LEVEL: deliver shreg.
    - Else: pulse frame_err for the next cycle and discard the word.
    - Either way, go to ARM.
- busy=1 while state is DATA or STOP; registered state decode, no glitch path from linha.
- Delivery is registered, on the clock edge ending the STOP cycle:
  - If valid=0, or ack=1 in that same cycle: palavra <= shreg, valid <= 1.
  - If valid=1 and ack=0: palavra and valid unchanged; new word dropped; overrun pulses 1 cycle.
- Handshake: when valid=1 and ack=1, the word is consumed and valid goes 0 next cycle, unless a delivery occurs in the same cycle (see above). ack while valid=0 is ignored.
- Latency: valid rises on the cycle after the stop bit, i.e. start bit at cycle t gives valid=1 at t+DATA_W+2.
- Back-to-back frames:
  - The stop cycle is followed by the ARM cycle, which sees the idle 1.
  - IDLE then catches the next start with no frame lost at the minimum 1-cycle gap.
- Line low during ARM: stay in ARM; no start detected.
- Reset mid-frame: partial data discarded, no error pulses, buffer cleared.
- Counter width: $clog2(DATA_W) bits, never wraps below 0 (DATA exits at 0).

Decomposition:
- Shared package tx_rx_pkg:
  - rx_state_t enum {ARM, IDLE, DATA, STOP} (logic [1:0]);
  - DATA_W_DEF=16;
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL_DEF=1'b0.
- `tx` and `rx` both import this package.
- No sub-module: the output buffer is a few flops inside rx.

Test Plan:
- Reset with linha=1, drive frame 0x A5C3 (start, bits MSB first, stop=0, idle) -> valid=1 at t+18, palavra=16'hA5C3, busy=1 for 17 cycles, no error pulses.
- Two back-to-back frames 0x0001 then 0xFFFF with 1 idle cycle, ack pulsed on each valid -> both words delivered in order, overrun=0.
- Frame 0x1234 delivered, ack held 0, frame 0xBEEF sent -> overrun pulses once, palavra stays 16'h1234, valid stays 1.
- Frame with stop bit driven 1 -> frame_err 1-cycle pulse, valid unchanged; next good frame 0x00FF received correctly.
- Reset released with linha=0 for 5 cycles, then 1, then frame 0x8000 -> no false start; palavra=16'h8000.
- Assert reset after 7 data bits of 0x5555, release, send 0xAAAA -> after reset palavra=0, valid=0; then palavra=16'hAAAA with no error pulses.
